shift_display_controller: RTL and testbench

Upstream stage of the serial display shift chain. Captures BCD/hex digit values and decimal-point flags, encodes them to 7-segment patterns, and presents the packed word to the downstream shift stage. Issues the one-cycle start strobe, waits for the shift to finish, then drives the output-register latch pulse. Refresh requests that arrive mid-transfer are queued one-deep.

---
 rtl/shift_display_controller.sv | 195 +++++++++++++++++++
 tb/tb_shift_display_controller.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_display_controller.sv
// shift_display_controller
// Upstream stage of the serial 7-segment display chain. Captures digit values
// and decimal points, encodes them to segment patterns, then starts the
// downstream shift stage, waits for it to finish and pulses the output latch.
// Refresh requests that arrive mid-transfer are merged into one pending request.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).

module shift_display_controller #(
  parameter int unsigned NUM_DIGITS       = 4,
  parameter int unsigned LATCH_STB_CYCLES = 2
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_clk_stb,
  input  logic                    i_refresh_stb,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic                    i_shift_busy,
  output logic [8*NUM_DIGITS-1:0] o_parallel_data,
  output logic                    o_shift_start_stb,
  output logic                    o_serial_latch,
  output logic                    o_busy
);

  localparam int unsigned DATA_W  = 8 * NUM_DIGITS;
  localparam int unsigned LATCH_N = (LATCH_STB_CYCLES < 1) ? 1 : LATCH_STB_CYCLES;
  localparam int unsigned LCNT_W  = (LATCH_N > 1) ? $clog2(LATCH_N) : 1;
  localparam int unsigned WAIT_W  = 2;

  // Last cycle spent waiting for the shift stage to raise busy (4 cycles total)
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(3);
  localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LATCH_N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_LATCH
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [WAIT_W-1:0]   w_wait_cnt_nx;
  logic [LCNT_W-1:0]   r_latch_cnt;
  logic [LCNT_W-1:0]   w_latch_cnt_nx;
  logic                r_pending;
  logic                w_pending_nx;
  logic                w_load;
  logic [DATA_W-1:0]   w_encoded;
  logic [DATA_W-1:0]   r_parallel_data;
  logic                r_shift_start_stb;
  logic                r_serial_latch;
  logic                r_busy;

  // Hex digit to {g,f,e,d,c,b,a} segment pattern
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Encode all digits, scanning from the most significant digit downward
  always_comb begin
    logic [3:0] w_digit;
    logic [6:0] w_seg;
`ifdef LEADING_ZERO_BLANK_EN
    logic       w_lead;
    w_lead    = 1'b1;
`endif
    w_encoded = '0;
    w_digit   = '0;
    w_seg     = '0;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      w_digit = i_digits[4*k +: 4];
      w_seg   = seg7(w_digit);
`ifdef LEADING_ZERO_BLANK_EN
      if ((k != 0) && w_lead && (w_digit == 4'h0)) begin
        w_seg = 7'h00;
      end
      if (w_digit != 4'h0) begin
        w_lead = 1'b0;
      end
`endif
      w_encoded[8*k +: 8] = {i_dp[k], w_seg};
    end
  end

  // Next-state, counter and pending-request logic
  always_comb begin
    w_next         = r_state;
    w_wait_cnt_nx  = r_wait_cnt;
    w_latch_cnt_nx = r_latch_cnt;
    w_pending_nx   = r_pending;
    w_load         = 1'b0;

    // A request outside IDLE (including the cycle we return to IDLE) is queued
    if (i_refresh_stb) begin
      w_pending_nx = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (i_refresh_stb || r_pending) begin
          w_next       = S_LOAD;
          w_pending_nx = 1'b0;
        end
      end
      S_LOAD: begin
        w_load = 1'b1;
        w_next = S_START;
      end
      S_START: begin
        w_wait_cnt_nx = '0;
        w_next        = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (i_shift_busy || (r_wait_cnt == WAIT_LAST)) begin
          w_next = S_WAIT_DONE;
        end else begin
          w_wait_cnt_nx = WAIT_W'(r_wait_cnt + WAIT_W'(1));
        end
      end
      S_WAIT_DONE: begin
        if (!i_shift_busy) begin
          w_latch_cnt_nx = '0;
          w_next         = S_LATCH;
        end
      end
      S_LATCH: begin
        if (i_clk_stb) begin
          if (r_latch_cnt == LCNT_LAST) begin
            w_latch_cnt_nx = '0;
            w_next         = S_IDLE;
          end else begin
            w_latch_cnt_nx = LCNT_W'(r_latch_cnt + LCNT_W'(1));
          end
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; outputs follow the next state
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state           <= S_IDLE;
      r_wait_cnt        <= '0;
      r_latch_cnt       <= '0;
      r_pending         <= 1'b0;
      r_parallel_data   <= '0;
      r_shift_start_stb <= 1'b0;
      r_serial_latch    <= 1'b0;
      r_busy            <= 1'b0;
    end else begin
      r_state           <= w_next;
      r_wait_cnt        <= w_wait_cnt_nx;
      r_latch_cnt       <= w_latch_cnt_nx;
      r_pending         <= w_pending_nx;
      if (w_load) begin
        r_parallel_data <= w_encoded;
      end
      r_shift_start_stb <= (w_next == S_START);
      r_serial_latch    <= (w_next == S_LATCH);
      r_busy            <= (w_next != S_IDLE);
    end
  end

  assign o_parallel_data   = r_parallel_data;
  assign o_shift_start_stb = r_shift_start_stb;
  assign o_serial_latch    = r_serial_latch;
  assign o_busy            = r_busy;

endmodule

// File: tb/tb_shift_display_controller.sv
// Directed testbench for shift_display_controller with a simple shift-stage
// model (busy for 32 serial strobes after each start pulse).

module tb_shift_display_controller;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned LATCH_STB  = 2;
  localparam int unsigned SHIFT_LEN  = 32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk_stb = 1'b0;
  logic        refresh_stb = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp = '0;
  logic        shift_busy = 1'b0;
  logic [31:0] parallel_data;
  logic        shift_start_stb;
  logic        serial_latch;
  logic        busy;

  int compared = 0;
  int failed   = 0;

  // Monitor / model state
  int          stb_div = 0;
  int          sh_cnt = 0;
  bit          shift_en = 1'b1;
  int          n_starts = 0;
  int          n_latch_stbs = 0;
  int          n_latch_cycles = 0;
  int          n_overlap = 0;
  int          n_latch_while_busy = 0;
  int          n_data_chg = 0;
  int          pulse_stbs = 0;
  logic [31:0] prev_data = '0;

  shift_display_controller #(
    .NUM_DIGITS(NUM_DIGITS),
    .LATCH_STB_CYCLES(LATCH_STB)
  ) dut (
    .i_clk(clk),
    .i_reset_n(reset_n),
    .i_clk_stb(clk_stb),
    .i_refresh_stb(refresh_stb),
    .i_digits(digits),
    .i_dp(dp),
    .i_shift_busy(shift_busy),
    .o_parallel_data(parallel_data),
    .o_shift_start_stb(shift_start_stb),
    .o_serial_latch(serial_latch),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  // Strobe generator, shift-stage model and output monitor
  always @(negedge clk) begin
    stb_div = (stb_div == 3) ? 0 : stb_div + 1;
    clk_stb = (stb_div == 0);
    if (!reset_n) begin
      shift_busy = 1'b0;
      sh_cnt     = 0;
    end else if (shift_start_stb) begin
      n_starts++;
      if (shift_en) begin
        shift_busy = 1'b1;
        sh_cnt     = 0;
      end
    end else if (shift_busy && clk_stb) begin
      sh_cnt++;
      if (sh_cnt == SHIFT_LEN) shift_busy = 1'b0;
    end
    if (serial_latch) begin
      n_latch_cycles++;
      if (clk_stb) begin
        n_latch_stbs++;
        pulse_stbs++;
      end
      if (shift_busy) n_latch_while_busy++;
    end else begin
      pulse_stbs = 0;
    end
    if (serial_latch && shift_start_stb) n_overlap++;
    if (parallel_data != prev_data) n_data_chg++;
    prev_data = parallel_data;
  end

  // Drive a one-cycle refresh; returns at the negedge of the LOAD cycle
  task automatic issue_refresh(input logic [15:0] d, input logic [3:0] p);
    @(negedge clk);
    digits      = d;
    dp          = p;
    refresh_stb = 1'b1;
    @(negedge clk);
    refresh_stb = 1'b0;
  endtask

  // Wait until the controller stays idle for 3 cycles, bounded
  task automatic wait_quiet(input string name, input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < budget) begin
      @(negedge clk);
      n++;
      quiet = busy ? 0 : quiet + 1;
    end
    compared++;
    if (quiet < 3) begin
      failed++;
      $display("FAIL %s_timeout: busy=%0b after %0d cycles, required idle", name, busy, n);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    compared++;
    if (parallel_data !== 32'h0) begin
      failed++; $display("FAIL reset_data: got %h required %h", parallel_data, 32'h0);
    end
    compared++;
    if (shift_start_stb !== 1'b0) begin
      failed++; $display("FAIL reset_start: got %b required 0", shift_start_stb);
    end
    compared++;
    if (serial_latch !== 1'b0 || n_latch_cycles != 0) begin
      failed++; $display("FAIL reset_latch: got %b (%0d cycles) required 0", serial_latch, n_latch_cycles);
    end
    compared++;
    if (busy !== 1'b0) begin
      failed++; $display("FAIL reset_busy: got %b required 0", busy);
    end
  endtask

  // Full transfer: latency, data, single start, latch width, return to idle
  task automatic test_transfer(input string name, input logic [15:0] d,
                               input logic [3:0] p, input logic [31:0] exp);
    int s0 = n_starts;
    int l0 = n_latch_stbs;
    int c0 = n_data_chg;
    int b0 = n_latch_while_busy;
    issue_refresh(d, p);
    compared++;
    if (shift_start_stb !== 1'b0 || busy !== 1'b1) begin
      failed++; $display("FAIL %s_load: start=%b busy=%b required start=0 busy=1", name, shift_start_stb, busy);
    end
    @(negedge clk);
    compared++;
    if (shift_start_stb !== 1'b1) begin
      failed++; $display("FAIL %s_start_latency: got %b required 1", name, shift_start_stb);
    end
    compared++;
    if (parallel_data !== exp) begin
      failed++; $display("FAIL %s_data: got %h required %h", name, parallel_data, exp);
    end
    wait_quiet(name, 1000);
    compared++;
    if (n_starts - s0 != 1) begin
      failed++; $display("FAIL %s_starts: got %0d required 1", name, n_starts - s0);
    end
    compared++;
    if (n_latch_stbs - l0 != int'(LATCH_STB) || serial_latch !== 1'b0) begin
      failed++; $display("FAIL %s_latch_stbs: got %0d required %0d", name, n_latch_stbs - l0, LATCH_STB);
    end
    compared++;
    if (n_latch_while_busy != b0 || n_overlap != 0) begin
      failed++; $display("FAIL %s_latch_timing: busy_overlap=%0d start_overlap=%0d required 0", name,
                         n_latch_while_busy - b0, n_overlap);
    end
    compared++;
    if (parallel_data !== exp || n_data_chg - c0 > 1) begin
      failed++; $display("FAIL %s_data_hold: got %h changes=%0d required %h at most 1 change", name,
                         parallel_data, n_data_chg - c0, exp);
    end
  endtask

  // Three requests mid-shift merge into one extra transfer with later digits
  task automatic test_back_to_back();
    int s0 = n_starts;
    int l0 = n_latch_stbs;
    issue_refresh(16'h1234, 4'b0000);
    @(negedge clk);
    compared++;
    if (shift_start_stb !== 1'b1 || parallel_data !== 32'h065B4F66) begin
      failed++; $display("FAIL b2b_first: start=%b data=%h required 1 065b4f66", shift_start_stb, parallel_data);
    end
    repeat (10) @(negedge clk);
    digits = 16'h9999;
    for (int i = 0; i < 3; i++) begin
      refresh_stb = 1'b1;
      @(negedge clk);
      refresh_stb = 1'b0;
      repeat (3) @(negedge clk);
    end
    compared++;
    if (parallel_data !== 32'h065B4F66) begin
      failed++; $display("FAIL b2b_hold: got %h required 065b4f66", parallel_data);
    end
    wait_quiet("b2b", 2000);
    compared++;
    if (n_starts - s0 != 2) begin
      failed++; $display("FAIL b2b_starts: got %0d required 2", n_starts - s0);
    end
    compared++;
    if (parallel_data !== 32'h6F6F6F6F) begin
      failed++; $display("FAIL b2b_data: got %h required 6f6f6f6f", parallel_data);
    end
    compared++;
    if (n_latch_stbs - l0 != 2 * int'(LATCH_STB)) begin
      failed++; $display("FAIL b2b_latch_stbs: got %0d required %0d", n_latch_stbs - l0, 2 * LATCH_STB);
    end
  endtask

  // Request on the exact cycle the FSM returns to IDLE is still serviced
  task automatic test_return_edge();
    int  s0 = n_starts;
    bit  hit = 1'b0;
    int  n = 0;
    issue_refresh(16'h1234, 4'b0000);
    while (!hit && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
      if (serial_latch && clk_stb && pulse_stbs == int'(LATCH_STB)) hit = 1'b1;
    end
    compared++;
    if (!hit) begin
      failed++; $display("FAIL edge_find: latch end not seen in %0d cycles, required seen", n);
    end
    digits      = 16'h5678;
    refresh_stb = 1'b1;
    @(negedge clk);
    refresh_stb = 1'b0;
    wait_quiet("edge", 1000);
    compared++;
    if (n_starts - s0 != 2) begin
      failed++; $display("FAIL edge_starts: got %0d required 2", n_starts - s0);
    end
    compared++;
    if (parallel_data !== 32'h6D7D077F) begin
      failed++; $display("FAIL edge_data: got %h required 6d7d077f", parallel_data);
    end
  endtask

  // Zero-latency shift stage: busy never rises, timeout path must complete
  task automatic test_no_busy();
    int s0 = n_starts;
    int l0 = n_latch_stbs;
    shift_en = 1'b0;
    issue_refresh(16'h8F0E, 4'b0001);
    wait_quiet("nobusy", 200);
    shift_en = 1'b1;
    compared++;
    if (n_starts - s0 != 1 || n_latch_stbs - l0 != int'(LATCH_STB)) begin
      failed++; $display("FAIL nobusy_count: starts=%0d latch_stbs=%0d required 1 %0d", n_starts - s0,
                         n_latch_stbs - l0, LATCH_STB);
    end
    compared++;
    if (parallel_data !== 32'h7F713FF9) begin
      failed++; $display("FAIL nobusy_data: got %h required 7f713ff9", parallel_data);
    end
  endtask

  // Reset during WAIT_DONE aborts without a latch pulse
  task automatic test_reset_abort();
    int lc;
    int s0;
    issue_refresh(16'h1234, 4'b0000);
    repeat (12) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    compared++;
    if (busy !== 1'b0 || serial_latch !== 1'b0 || shift_start_stb !== 1'b0) begin
      failed++; $display("FAIL abort_ctrl: busy=%b latch=%b start=%b required 0 0 0", busy, serial_latch,
                         shift_start_stb);
    end
    compared++;
    if (parallel_data !== 32'h0) begin
      failed++; $display("FAIL abort_data: got %h required 0", parallel_data);
    end
    reset_n = 1'b1;
    lc = n_latch_cycles;
    s0 = n_starts;
    repeat (200) @(negedge clk);
    compared++;
    if (n_latch_cycles != lc || n_starts != s0 || busy !== 1'b0) begin
      failed++; $display("FAIL abort_quiet: latch_cycles=%0d starts=%0d busy=%b required 0 0 0",
                         n_latch_cycles - lc, n_starts - s0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_transfer("basic", 16'h1234, 4'b0000, 32'h065B4F66);
    test_transfer("hex", 16'hABCD, 4'b0100, 32'h77FC395E);
    test_back_to_back();
    test_return_edge();
    test_no_busy();
    test_reset_abort();
`ifdef LEADING_ZERO_BLANK_EN
    test_transfer("lz45", 16'h0045, 4'b0000, 32'h0000666D);
    test_transfer("lz00", 16'h0000, 4'b0000, 32'h0000003F);
    test_transfer("lzdp", 16'h0045, 4'b1000, 32'h8000666D);
`else
    test_transfer("lz45", 16'h0045, 4'b0000, 32'h3F3F666D);
    test_transfer("lz00", 16'h0000, 4'b0000, 32'h3F3F3F3F);
    test_transfer("lzdp", 16'h0045, 4'b1000, 32'hBF3F666D);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
